// File: rtl/vgg_block_demo_if.sv
// Pixel-stream bundle for the CReLU + 2x2 max-pool stage: 8 float32 channels in, 16 out.
// The master drives the input stream and observes the pooled output; the slave is the pool stage.
interface vgg_block_demo_if #(
    parameter int DW = 32
);
    logic                 valid_in;
    logic [7:0][DW-1:0]   data_in;
    logic [15:0][DW-1:0]  data_out;
    logic                 valid_out;
    logic                 done;

    modport master (
        output valid_in, data_in,
        input  data_out, valid_out, done
    );

    modport slave (
        input  valid_in, data_in,
        output data_out, valid_out, done
    );
endinterface

// File: rtl/vgg_block_demo.sv
// Streaming CReLU (8 -> 16 channels) followed by 2x2/stride-2 max-pool over a raster frame.
// Pipeline: stage-1 CReLU register, pairing/line-buffer stage, pooled output register.
module vgg_block_demo #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic            clk,
    input  logic            resetn,
    vgg_block_demo_if.slave bus
);
    localparam int NI    = 8;
    localparam int NO    = 2 * NI;
    localparam int DEPTH = WIDTH / 2;
    localparam int CW    = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW    = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;

    typedef logic [NO-1:0][DATA_WIDTH-1:0] vec_t;

    // CReLU outputs are never negative, so the sign bit plays no part in the compare.
    function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          s1_valid_q, s1_valid_d;
    logic [CW-1:0] s1_col_q, s1_col_d;
    logic          s1_row_odd_q, s1_row_odd_d;
    logic          s1_last_q, s1_last_d;
    vec_t          s1_data_q, s1_data_d;
    vec_t          hold_q, hold_d;
    vec_t          hmax_q, hmax_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_last_q, s2_last_d;
    vec_t          out_q, out_d;
    logic          valid_out_q, valid_out_d;
    logic          done_q, done_d;

    vec_t          crelu;
    vec_t          hmax;
    vec_t          pooled;
    vec_t          lb_rd_q;
    logic          lb_we, lb_re;
    logic [AW-1:0] lb_addr;

    for (genvar gi = 0; gi < NI; gi++) begin : g_crelu
        assign crelu[gi]      = bus.data_in[gi][DATA_WIDTH-1] ? '0 : bus.data_in[gi];
        assign crelu[gi + NI] = bus.data_in[gi][DATA_WIDTH-1]
                              ? {1'b0, bus.data_in[gi][DATA_WIDTH-2:0]} : '0;
    end

    for (genvar gi = 0; gi < NO; gi++) begin : g_pool
        assign hmax[gi]   = vmax(hold_q[gi], s1_data_q[gi]);
        assign pooled[gi] = vmax(lb_rd_q[gi], hmax_q[gi]);
    end

    // Raster position of the pixel being accepted, plus the stage-1 capture.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.valid_in) begin
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        s1_valid_d   = bus.valid_in;
        s1_col_d     = col_q;
        s1_row_odd_d = row_q[0];
        s1_last_d    = (col_q == CW'(WIDTH - 1)) && (row_q == RW'(HEIGHT - 1));
        s1_data_d    = crelu;
    end

    // Even column parks its value; odd column either fills the line buffer (even row)
    // or reads the partner row back for the final vertical max (odd row).
    always_comb begin
        hold_d = hold_q;
        lb_we  = 1'b0;
        lb_re  = 1'b0;
        if (s1_valid_q) begin
            if (!s1_col_q[0]) begin
                hold_d = s1_data_q;
            end else if (!s1_row_odd_q) begin
                lb_we = 1'b1;
            end else begin
                lb_re = 1'b1;
            end
        end
        lb_addr    = AW'(s1_col_q >> 1);
        hmax_d     = hmax;
        s2_valid_d = lb_re;
        s2_last_d  = s1_last_q;
    end

    always_comb begin
        out_d       = s2_valid_q ? pooled : out_q;
        valid_out_d = s2_valid_q;
        done_d      = s2_valid_q & s2_last_q;
    end

    // Line buffer holds one row of horizontal maxima; read port is registered.
    logic [NO*DATA_WIDTH-1:0] lb_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (lb_we) lb_mem[lb_addr] <= hmax;
        if (lb_re) lb_rd_q <= lb_mem[lb_addr];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_col_q     <= '0;
            s1_row_odd_q <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_data_q    <= '0;
            hold_q       <= '0;
            hmax_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            out_q        <= '0;
            valid_out_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            s1_valid_q   <= s1_valid_d;
            s1_col_q     <= s1_col_d;
            s1_row_odd_q <= s1_row_odd_d;
            s1_last_q    <= s1_last_d;
            s1_data_q    <= s1_data_d;
            hold_q       <= hold_d;
            hmax_q       <= hmax_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            out_q        <= out_d;
            valid_out_q  <= valid_out_d;
            done_q       <= done_d;
        end
    end

    assign bus.data_out  = out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_vgg_block_demo.sv
// Scoreboard bench for vgg_block_demo on a 4x4 frame: a frame-level CReLU/max-pool model
// queues expected strobes (data, done, arrival cycle); a negedge monitor pops and compares.
module tb_vgg_block_demo;
    localparam int W = 4;
    localparam int H = 4;

    typedef logic [7:0][31:0]  px_t;
    typedef logic [15:0][31:0] out_t;
    typedef struct {
        out_t data;
        logic done;
        int   cyc;
    } exp_t;

    localparam logic [31:0] FLT [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    localparam logic [31:0] EXP2 [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vgg_block_demo_if #(.DW(32)) bus ();

    vgg_block_demo #(
        .DATA_WIDTH(32),
        .WIDTH     (W),
        .HEIGHT    (H)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_done = 0;
    int   pidx = 0;
    exp_t exp_q [$];
    out_t obs_q [$];
    logic [31:0] frame [H][W][16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] relu_pos(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    function automatic logic [31:0] relu_neg(input logic [31:0] x);
        return x[31] ? {1'b0, x[30:0]} : 32'h0;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %08h, required %08h", nm, act, req);
        end
    endtask

    // Model: keep the whole CReLU'd frame; each odd/odd pixel closes a 2x2 window.
    task automatic put_pixel(input px_t px);
        int   r, c;
        out_t v;
        exp_t e;
        logic [31:0] m;
        bus.valid_in = 1'b1;
        bus.data_in  = px;
        r = pidx / W;
        c = pidx % W;
        for (int ch = 0; ch < 8; ch++) begin
            frame[r][c][ch]     = relu_pos(px[ch]);
            frame[r][c][ch + 8] = relu_neg(px[ch]);
        end
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            for (int ch = 0; ch < 16; ch++) begin
                m = 32'h0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (frame[r - dr][c - dc][ch] > m) m = frame[r - dr][c - dc][ch];
                v[ch] = m;
            end
            e.data = v;
            e.done = (r == H - 1) && (c == W - 1);
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
        end
        pidx = (pidx + 1) % (W * H);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b0;
            bus.data_in  = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
    endtask

    function automatic px_t rand_px();
        px_t p;
        for (int ch = 0; ch < 8; ch++) p[ch] = $urandom();
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain_timeout: %0d strobes still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.done && !bus.valid_out) begin
                n_vec++;
                n_mis++;
                $display("FAIL done_without_valid: got done=1 valid_out=0, required done=0");
            end
            if (bus.valid_out) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_strobe: got valid_out=1 at cycle %0d, required none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e.data || bus.done !== e.done || cyc != e.cyc) begin
                        n_mis++;
                        $display("FAIL strobe: got data=%h done=%b cyc=%0d, required data=%h done=%b cyc=%0d",
                                 bus.data_out, bus.done, cyc, e.data, e.done, e.cyc);
                    end
                end
                obs_q.push_back(bus.data_out);
                if (bus.done) n_done++;
            end
        end
    end

    initial begin
        int   base, d0;
        px_t  px;
        px_t  f1 [16];

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        @(posedge clk); #1;

        // Reset held with valid_in toggling: outputs must stay zero.
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = (i % 2 == 0);
            bus.data_in  = rand_px();
            @(negedge clk);
            chk32("rst_valid_out", 32'(bus.valid_out), 32'h0);
            chk32("rst_done", 32'(bus.done), 32'h0);
            for (int ch = 0; ch < 16; ch++) chk32("rst_data_out", bus.data_out[ch], 32'h0);
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        resetn = 1'b1;
        pidx = 0;
        exp_q.delete();

        // Ramp 1.0..16.0 on ch0, continuous.
        base = obs_q.size(); d0 = n_done;
        for (int p = 0; p < 16; p++) begin
            px = '0; px[0] = FLT[p];
            put_pixel(px);
        end
        drain();
        chk32("t2_count", 32'(obs_q.size() - base), 32'd4);
        chk32("t2_done", 32'(n_done - d0), 32'd1);
        if (obs_q.size() >= base + 4)
            for (int k = 0; k < 4; k++) begin
                chk32("t2_ch0", obs_q[base + k][0], EXP2[k]);
                chk32("t2_ch8", obs_q[base + k][8], 32'h0);
            end

        // ch3 negative everywhere, -7.0 at pixel (1,0).
        base = obs_q.size();
        for (int p = 0; p < 16; p++) begin
            px = '0; px[3] = (p == W) ? 32'hC0E00000 : 32'hC0200000;
            put_pixel(px);
        end
        drain();
        chk32("t3_count", 32'(obs_q.size() - base), 32'd4);
        if (obs_q.size() >= base + 4)
            for (int k = 0; k < 4; k++) begin
                chk32("t3_ch11", obs_q[base + k][11], (k == 0) ? 32'h40E00000 : 32'h40200000);
                chk32("t3_ch3", obs_q[base + k][3], 32'h0);
            end

        // Ramp again with random input gaps.
        base = obs_q.size(); d0 = n_done;
        for (int p = 0; p < 16; p++) begin
            gap($urandom_range(0, 3));
            px = '0; px[0] = FLT[p];
            put_pixel(px);
        end
        drain();
        chk32("t4_count", 32'(obs_q.size() - base), 32'd4);
        chk32("t4_done", 32'(n_done - d0), 32'd1);
        if (obs_q.size() >= base + 4)
            for (int k = 0; k < 4; k++) chk32("t4_ch0", obs_q[base + k][0], EXP2[k]);

        // Two frames back to back, second is the first negated.
        base = obs_q.size(); d0 = n_done;
        for (int p = 0; p < 16; p++) f1[p] = rand_px();
        for (int p = 0; p < 16; p++) put_pixel(f1[p]);
        for (int p = 0; p < 16; p++) put_pixel(f1[p] ^ {8{32'h80000000}});
        drain();
        chk32("t5_count", 32'(obs_q.size() - base), 32'd8);
        chk32("t5_done", 32'(n_done - d0), 32'd2);
        if (obs_q.size() >= base + 8)
            for (int k = 0; k < 4; k++)
                for (int ch = 0; ch < 8; ch++)
                    chk32("t5_neg_vs_pos", obs_q[base + 4 + k][8 + ch], obs_q[base + k][ch]);

        // Reset mid-frame after 6 pixels, then a frame carrying -0.0 on ch5.
        for (int p = 0; p < 6; p++) put_pixel(rand_px());
        resetn = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        pidx = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        base = obs_q.size(); d0 = n_done;
        for (int p = 0; p < 16; p++) begin
            px = rand_px(); px[5] = 32'h80000000;
            put_pixel(px);
        end
        drain();
        chk32("t6_count", 32'(obs_q.size() - base), 32'd4);
        chk32("t6_done", 32'(n_done - d0), 32'd1);
        if (obs_q.size() >= base + 4)
            for (int k = 0; k < 4; k++) begin
                chk32("t6_ch5", obs_q[base + k][5], 32'h0);
                chk32("t6_ch13", obs_q[base + k][13], 32'h0);
            end

        // Random frames with random gaps, scoreboard only.
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 16; p++) begin
                if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
                put_pixel(rand_px());
            end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        n_mis++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
